// File: rtl/pool_window_feeder.sv
// Gathers a serial sample stream into 5-sample windows for the max-pooling unit.
// Supports overlapping windows via STRIDE and zero-pads a short final window.
module pool_window_feeder #(
  parameter int DATA_W = 8,
  parameter int STRIDE = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic              win_en,
  output logic              win_last,
  input  logic              m_ready
);

  localparam int WIN_N = 5;

  generate
    if (STRIDE < 1 || STRIDE > WIN_N) begin : g_bad_stride
      $error("pool_window_feeder: STRIDE must be in 1..5");
    end
  endgenerate

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_cnt;
  logic              r_win_last;
  logic [DATA_W-1:0] w_buf [WIN_N];
  logic [DATA_W-1:0] w_win [WIN_N];
  logic              w_accept;
  logic              w_release;
  logic              w_close;
  logic [2:0]        w_cnt_inc;

  assign w_accept  = s_valid && s_ready;
  assign w_release = (r_state == ST_HOLD) && m_ready;
  assign w_cnt_inc = r_cnt + 3'd1;
  // A window closes on the fifth sample or early on the frame's last sample.
  assign w_close   = w_accept && ((w_cnt_inc == 3'(WIN_N)) || s_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL: if (w_close)  w_state_next = ST_HOLD;
      ST_HOLD: if (m_ready)  w_state_next = ST_FILL;
      default:               w_state_next = ST_FILL;
    endcase
  end

  always_comb begin
    s_ready = rst_n && (r_state == ST_FILL);
    win_en  = (r_state == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= 3'd0;
      r_win_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end else if (w_release) begin
        r_cnt <= r_win_last ? 3'd0 : 3'(WIN_N - STRIDE);
      end
      if (w_close) begin
        r_win_last <= s_last;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN_N; gi++) begin : g_slot
      logic [DATA_W-1:0] r_buf_elem;
      logic [DATA_W-1:0] r_win_elem;

      if (gi < WIN_N - STRIDE) begin : g_keep
        // Overlap samples shift down by STRIDE so the next window starts with them.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_buf_elem <= '0;
          end else if (w_accept && (r_cnt == 3'(gi))) begin
            r_buf_elem <= s_data;
          end else if (w_release) begin
            r_buf_elem <= r_win_last ? '0 : w_buf[gi+STRIDE];
          end
        end
      end else begin : g_drop
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_buf_elem <= '0;
          end else if (w_accept && (r_cnt == 3'(gi))) begin
            r_buf_elem <= s_data;
          end else if (w_release && r_win_last) begin
            r_buf_elem <= '0;
          end
        end
      end

      // The closing sample is still being written to the buffer, so take it from s_data.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_win_elem <= '0;
        end else if (w_close) begin
          if (3'(gi) < r_cnt) begin
            r_win_elem <= w_buf[gi];
          end else if (3'(gi) == r_cnt) begin
            r_win_elem <= s_data;
          end else begin
            r_win_elem <= '0;
          end
        end
      end

      assign w_buf[gi] = r_buf_elem;
      assign w_win[gi] = r_win_elem;
    end
  endgenerate

  assign win1     = w_win[0];
  assign win2     = w_win[1];
  assign win3     = w_win[2];
  assign win4     = w_win[3];
  assign win5     = w_win[4];
  assign win_last = r_win_last;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder: one STRIDE=5 instance and one STRIDE=2 instance.
module tb_pool_window_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] s_data5 = '0, s_data2 = '0;
  logic       s_valid5 = 1'b0, s_valid2 = 1'b0;
  logic       s_last5 = 1'b0, s_last2 = 1'b0;
  logic       m_ready5 = 1'b0, m_ready2 = 1'b0;
  logic       s_ready5, s_ready2;
  logic [7:0] w5_1, w5_2, w5_3, w5_4, w5_5;
  logic [7:0] w2_1, w2_2, w2_3, w2_4, w2_5;
  logic       win_en5, win_en2, win_last5, win_last2;
  logic [39:0] win5_vec, win2_vec;

  int n_pass = 0;
  int n_total = 0;

  assign win5_vec = {w5_1, w5_2, w5_3, w5_4, w5_5};
  assign win2_vec = {w2_1, w2_2, w2_3, w2_4, w2_5};

  always #5 clk = ~clk;

  pool_window_feeder #(.DATA_W(8), .STRIDE(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data5), .s_valid(s_valid5), .s_ready(s_ready5), .s_last(s_last5),
    .win1(w5_1), .win2(w5_2), .win3(w5_3), .win4(w5_4), .win5(w5_5),
    .win_en(win_en5), .win_last(win_last5), .m_ready(m_ready5)
  );

  pool_window_feeder #(.DATA_W(8), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2), .s_last(s_last2),
    .win1(w2_1), .win2(w2_2), .win3(w2_3), .win4(w2_4), .win5(w2_5),
    .win_en(win_en2), .win_last(win_last2), .m_ready(m_ready2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push5(input logic [7:0] d, input logic l);
    s_valid5 = 1'b1; s_data5 = d; s_last5 = l;
    tick();
    s_valid5 = 1'b0; s_last5 = 1'b0;
  endtask

  task automatic push2(input logic [7:0] d, input logic l);
    s_valid2 = 1'b1; s_data2 = d; s_last2 = l;
    tick();
    s_valid2 = 1'b0; s_last2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_total++;
    if (win5_vec !== 40'd0) $display("FAIL reset_win got=%h exp=0", win5_vec); else n_pass++;
    n_total++;
    if ({win_en5, win_last5, s_ready5} !== 3'b000)
      $display("FAIL reset_ctrl got en/last/rdy=%b exp=000", {win_en5, win_last5, s_ready5});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (s_ready5 !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", s_ready5); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    m_ready5 = 1'b1;
    push5(8'd10, 0); push5(8'd20, 0); push5(8'd30, 0); push5(8'd40, 0);
    n_total++;
    if (win_en5 !== 1'b0) $display("FAIL basic_no_early_window got=%b exp=0", win_en5); else n_pass++;
    push5(8'd50, 0);
    n_total++;
    if (win5_vec !== {8'd10, 8'd20, 8'd30, 8'd40, 8'd50})
      $display("FAIL basic_window got=%h exp=0a141e2832", win5_vec);
    else n_pass++;
    n_total++;
    if ({win_en5, s_ready5, win_last5} !== 3'b100)
      $display("FAIL basic_hold_ctrl got en/rdy/last=%b exp=100", {win_en5, s_ready5, win_last5});
    else n_pass++;
    tick();
    n_total++;
    if ({win_en5, s_ready5} !== 2'b01)
      $display("FAIL basic_release got en/rdy=%b exp=01", {win_en5, s_ready5});
    else n_pass++;
    $display("test_basic done window=%h", win5_vec);
  endtask

  task automatic test_backpressure();
    m_ready5 = 1'b0;
    push5(8'd10, 0); push5(8'd20, 0); push5(8'd30, 0); push5(8'd40, 0); push5(8'd50, 0);
    s_valid5 = 1'b1; s_data5 = 8'd60;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if ({win_en5, s_ready5} !== 2'b10 || win5_vec !== {8'd10, 8'd20, 8'd30, 8'd40, 8'd50})
        $display("FAIL bp_hold_%0d got en/rdy=%b win=%h exp en/rdy=10 win=0a141e2832",
                 c, {win_en5, s_ready5}, win5_vec);
      else n_pass++;
      tick();
    end
    m_ready5 = 1'b1;
    tick();
    m_ready5 = 1'b0;
    n_total++;
    if ({win_en5, s_ready5} !== 2'b01)
      $display("FAIL bp_release got en/rdy=%b exp=01", {win_en5, s_ready5});
    else n_pass++;
    tick();
    s_valid5 = 1'b0;
    push5(8'd70, 0); push5(8'd80, 0); push5(8'd90, 0); push5(8'd100, 0);
    n_total++;
    if (win5_vec !== {8'd60, 8'd70, 8'd80, 8'd90, 8'd100} || win_en5 !== 1'b1)
      $display("FAIL bp_next_window got en=%b win=%h exp en=1 win=3c46505a64", win_en5, win5_vec);
    else n_pass++;
    m_ready5 = 1'b1;
    tick();
    $display("test_backpressure done window=%h", win5_vec);
  endtask

  task automatic test_pad();
    push5(8'd7, 0); push5(8'd9, 0); push5(8'd3, 1);
    n_total++;
    if (win5_vec !== {8'd7, 8'd9, 8'd3, 8'd0, 8'd0})
      $display("FAIL pad_window got=%h exp=0709030000", win5_vec);
    else n_pass++;
    n_total++;
    if ({win_en5, win_last5} !== 2'b11)
      $display("FAIL pad_ctrl got en/last=%b exp=11", {win_en5, win_last5});
    else n_pass++;
    tick();
    push5(8'd1, 0); push5(8'd2, 0); push5(8'd3, 0); push5(8'd4, 0);
    n_total++;
    if (win_en5 !== 1'b0) $display("FAIL pad_fresh_cnt got en=%b exp=0", win_en5); else n_pass++;
    push5(8'd5, 0);
    n_total++;
    if (win5_vec !== {8'd1, 8'd2, 8'd3, 8'd4, 8'd5} || win_last5 !== 1'b0)
      $display("FAIL pad_fresh_window got=%h last=%b exp=0102030405 last=0", win5_vec, win_last5);
    else n_pass++;
    tick();
    $display("test_pad done");
  endtask

  task automatic test_stride2();
    m_ready2 = 1'b1;
    push2(8'd1, 0); push2(8'd2, 0); push2(8'd3, 0); push2(8'd4, 0); push2(8'd5, 0);
    n_total++;
    if (win2_vec !== {8'd1, 8'd2, 8'd3, 8'd4, 8'd5} || {win_en2, win_last2} !== 2'b10)
      $display("FAIL s2_win1 got=%h en/last=%b exp=0102030405 en/last=10", win2_vec, {win_en2, win_last2});
    else n_pass++;
    tick();
    push2(8'd6, 0);
    n_total++;
    if (win_en2 !== 1'b0) $display("FAIL s2_needs_new got en=%b exp=0", win_en2); else n_pass++;
    push2(8'd7, 0);
    n_total++;
    if (win2_vec !== {8'd3, 8'd4, 8'd5, 8'd6, 8'd7} || {win_en2, win_last2} !== 2'b10)
      $display("FAIL s2_win2 got=%h en/last=%b exp=0304050607 en/last=10", win2_vec, {win_en2, win_last2});
    else n_pass++;
    tick();
    push2(8'd8, 0); push2(8'd9, 1);
    n_total++;
    if (win2_vec !== {8'd5, 8'd6, 8'd7, 8'd8, 8'd9} || {win_en2, win_last2} !== 2'b11)
      $display("FAIL s2_win3 got=%h en/last=%b exp=0506070809 en/last=11", win2_vec, {win_en2, win_last2});
    else n_pass++;
    tick();
    push2(8'd20, 0); push2(8'd21, 0); push2(8'd22, 0); push2(8'd23, 0);
    n_total++;
    if (win_en2 !== 1'b0) $display("FAIL s2_fresh_cnt got en=%b exp=0", win_en2); else n_pass++;
    push2(8'd24, 0);
    n_total++;
    if (win2_vec !== {8'd20, 8'd21, 8'd22, 8'd23, 8'd24} || win_last2 !== 1'b0)
      $display("FAIL s2_fresh_window got=%h last=%b exp=1415161718 last=0", win2_vec, win_last2);
    else n_pass++;
    tick();
    $display("test_stride2 done");
  endtask

  task automatic test_full_last();
    push5(8'd5, 0); push5(8'd4, 0); push5(8'd3, 0); push5(8'd2, 0); push5(8'd1, 1);
    n_total++;
    if (win5_vec !== {8'd5, 8'd4, 8'd3, 8'd2, 8'd1} || {win_en5, win_last5} !== 2'b11)
      $display("FAIL fl_window got=%h en/last=%b exp=0504030201 en/last=11", win5_vec, {win_en5, win_last5});
    else n_pass++;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (win_en5 !== 1'b0) $display("FAIL fl_no_pad_%0d got en=%b exp=0", c, win_en5); else n_pass++;
      tick();
    end
    push5(8'd9, 0); push5(8'd8, 0); push5(8'd7, 0); push5(8'd6, 0); push5(8'd5, 0);
    n_total++;
    if (win5_vec !== {8'd9, 8'd8, 8'd7, 8'd6, 8'd5} || win_last5 !== 1'b0)
      $display("FAIL fl_next_frame got=%h last=%b exp=0908070605 last=0", win5_vec, win_last5);
    else n_pass++;
    tick();
    $display("test_full_last done");
  endtask

  task automatic test_reset_midfill();
    push5(8'd11, 0); push5(8'd22, 0); push5(8'd33, 0);
    rst_n = 1'b0;
    tick();
    n_total++;
    if (win5_vec !== 40'd0 || {win_en5, win_last5, s_ready5} !== 3'b000)
      $display("FAIL rst_mid got win=%h en/last/rdy=%b exp win=0 en/last/rdy=000",
               win5_vec, {win_en5, win_last5, s_ready5});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    push5(8'd1, 0); push5(8'd2, 0); push5(8'd3, 0); push5(8'd4, 0);
    n_total++;
    if (win_en5 !== 1'b0) $display("FAIL rst_no_stale got en=%b exp=0", win_en5); else n_pass++;
    push5(8'd5, 0);
    n_total++;
    if (win5_vec !== {8'd1, 8'd2, 8'd3, 8'd4, 8'd5} || win_en5 !== 1'b1)
      $display("FAIL rst_window got=%h en=%b exp=0102030405 en=1", win5_vec, win_en5);
    else n_pass++;
    tick();
    $display("test_reset_midfill done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_pad();
    test_stride2();
    test_full_last();
    test_reset_midfill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
